// File: rtl/raster_line_router_if.sv
// AXI4-Stream bundle shared by the raster input and the eight per-line lanes.
// Only the subset used by the line router is carried: data, handshake, tlast and tuser.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/raster_line_router.sv
// Steers raster line n of a video stream to lane n mod 8 through a single holding
// register, and flags line-width, line-length and start-of-frame framing errors.
module raster_line_router #(
    parameter int  PX_WIDTH    = 8,
    parameter int  MAX_LINE_PX = 4096,
    localparam int TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8,
    localparam int LW          = $clog2(MAX_LINE_PX + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi4_stream_if.slave         video_i,
    axi4_stream_if.master        lines_o [8],
    output logic                 stripe_done_o,
    output logic                 width_err_o,
    output logic                 len_err_o,
    output logic                 sof_err_o,
    output logic [15:0]          frame_cnt_o
);

    logic [7:0]             laneReady;
    logic                   accept;

    logic [2:0]             lnSel_q,      lnSel_d;
    logic [LW-1:0]          pxCnt_q,      pxCnt_d;
    logic [LW:0]            refLen_q,     refLen_d;
    logic                   refVld_q,     refVld_d;
    logic [15:0]            frameCnt_q,   frameCnt_d;
    logic                   stripeDone_q, stripeDone_d;
    logic                   widthErr_q,   widthErr_d;
    logic                   lenErr_q,     lenErr_d;
    logic                   sofErr_q,     sofErr_d;

    logic [TDATA_WIDTH-1:0] holdData_q,   holdData_d;
    logic                   holdLast_q,   holdLast_d;
    logic                   holdUser_q,   holdUser_d;
    logic [2:0]             holdLane_q,   holdLane_d;
    logic                   holdVld_q,    holdVld_d;

    logic [2:0]             lnBase;
    logic [LW-1:0]          pxBase;
    logic                   refVldBase;
    logic [LW:0]            lineLen;

    // Every lane sees the shared holding register; only the selected lane asserts tvalid.
    for (genvar g = 0; g < 8; g++) begin : gLane
        assign laneReady[g]      = lines_o[g].tready;
        assign lines_o[g].tvalid = holdVld_q && (holdLane_q == 3'(g));
        assign lines_o[g].tdata  = holdData_q;
        assign lines_o[g].tlast  = holdLast_q;
        assign lines_o[g].tuser  = holdUser_q;
    end

    assign video_i.tready = !holdVld_q || laneReady[holdLane_q];
    assign accept         = video_i.tvalid && video_i.tready;

    // SOF handling rewrites the "before" view of lane/count/reference so that a beat
    // carrying both tuser and tlast can fall straight through into the end-of-line rules.
    always_comb begin
        lnSel_d      = lnSel_q;
        pxCnt_d      = pxCnt_q;
        refLen_d     = refLen_q;
        refVld_d     = refVld_q;
        frameCnt_d   = frameCnt_q;
        stripeDone_d = 1'b0;
        widthErr_d   = 1'b0;
        lenErr_d     = 1'b0;
        sofErr_d     = 1'b0;
        holdData_d   = holdData_q;
        holdLast_d   = holdLast_q;
        holdUser_d   = holdUser_q;
        holdLane_d   = holdLane_q;
        holdVld_d    = holdVld_q;
        lnBase       = lnSel_q;
        pxBase       = pxCnt_q;
        refVldBase   = refVld_q;
        lineLen      = '0;

        if (accept) begin
            if (video_i.tuser) begin
                sofErr_d   = (lnSel_q != 3'd0) || (pxCnt_q != '0);
                lnBase     = 3'd0;
                pxBase     = '0;
                refVldBase = 1'b0;
                frameCnt_d = frameCnt_q + 16'd1;
            end

            holdData_d = video_i.tdata;
            holdLast_d = video_i.tlast;
            holdUser_d = video_i.tuser;
            holdLane_d = lnBase;
            holdVld_d  = 1'b1;

            if (video_i.tlast) begin
                lineLen      = (LW+1)'(pxBase) + (LW+1)'(1);
                pxCnt_d      = '0;
                lnSel_d      = lnBase + 3'd1;
                stripeDone_d = (lnBase == 3'd7);
                widthErr_d   = (lineLen[2:0] != 3'd0);
                refVld_d     = 1'b1;
                if (!refVldBase) begin
                    refLen_d = lineLen;
                end else begin
                    lenErr_d = (lineLen != refLen_q);
                end
            end else begin
                pxCnt_d  = (pxBase < LW'(MAX_LINE_PX)) ? pxBase + LW'(1) : pxBase;
                lnSel_d  = lnBase;
                refVld_d = refVldBase;
            end
        end else if (holdVld_q && laneReady[holdLane_q]) begin
            holdVld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lnSel_q      <= '0;
            pxCnt_q      <= '0;
            refLen_q     <= '0;
            refVld_q     <= 1'b0;
            frameCnt_q   <= '0;
            stripeDone_q <= 1'b0;
            widthErr_q   <= 1'b0;
            lenErr_q     <= 1'b0;
            sofErr_q     <= 1'b0;
            holdData_q   <= '0;
            holdLast_q   <= 1'b0;
            holdUser_q   <= 1'b0;
            holdLane_q   <= '0;
            holdVld_q    <= 1'b0;
        end else begin
            lnSel_q      <= lnSel_d;
            pxCnt_q      <= pxCnt_d;
            refLen_q     <= refLen_d;
            refVld_q     <= refVld_d;
            frameCnt_q   <= frameCnt_d;
            stripeDone_q <= stripeDone_d;
            widthErr_q   <= widthErr_d;
            lenErr_q     <= lenErr_d;
            sofErr_q     <= sofErr_d;
            holdData_q   <= holdData_d;
            holdLast_q   <= holdLast_d;
            holdUser_q   <= holdUser_d;
            holdLane_q   <= holdLane_d;
            holdVld_q    <= holdVld_d;
        end
    end

    assign stripe_done_o = stripeDone_q;
    assign width_err_o   = widthErr_q;
    assign len_err_o     = lenErr_q;
    assign sof_err_o     = sofErr_q;
    assign frame_cnt_o   = frameCnt_q;

endmodule

// File: doc/raster_line_router.md
# raster_line_router

Scheduler in front of the 8-line pixel-to-DCT adapter. It accepts a single raster video AXI4-Stream (tuser = start of frame, tlast = end of line) and steers each line, in order, to one of 8 per-line output streams: line n goes to lane n mod 8. It also checks that line width is a multiple of 8 and constant within a frame, and reports framing errors. The per-line FIFOs between this block and the adapter are outside this block.

## Interface
- PX_WIDTH, 8, pixel bit width; tdata width TDATA_WIDTH = PX_WIDTH rounded up to a multiple of 8.
- MAX_LINE_PX, 4096, maximum pixels per line; sets the width of the pixel counter, LW = $clog2(MAX_LINE_PX+1).
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- video_i  axi4_stream_if.slave  TDATA_WIDTH  raster input; uses tdata, tvalid, tready, tlast, tuser.
- lines_o[7:0]  axi4_stream_if.master  TDATA_WIDTH  per-line outputs; tdata, tvalid, tready, tlast, tuser.
- stripe_done_o  output  1  one-cycle pulse when the tlast of lane 7 is accepted on the input.
- width_err_o  output  1  one-cycle pulse: line length is not a multiple of 8.
- len_err_o  output  1  one-cycle pulse: line length differs from line 0 of the current frame.
- sof_err_o  output  1  one-cycle pulse: tuser arrived while ln_sel != 0 or mid-line.
- frame_cnt_o  output  16  count of accepted SOF beats; wraps at 16'hFFFF to 0.

## Operation
- **State**
  - ln_sel[2:0]: target lane.
  - px_cnt[LW-1:0]: pixels accepted in the current line.
  - ref_len[LW-1:0] and ref_vld: length of line 0 of the current frame, and whether it has been captured.
  - Output holding register: hold_data, hold_last, hold_user, hold_lane, hold_vld.
- **Input acceptance**
  - A beat is accepted on video_i.tvalid && video_i.tready.
  - The beat is copied into the holding register with hold_lane = the effective lane (see SOF below).
- **Output**
  - Only lane hold_lane drives tvalid = hold_vld; the other 7 lanes drive tvalid = 0.
  - All lanes share hold_data, hold_last and hold_user.
- **SOF beat (tuser = 1)**
  - Effective lane is 0; ln_sel is forced to 0.
  - px_cnt restarts: px_cnt = 1 after the beat, or 0 if the beat also has tlast.
  - ref_vld is cleared; frame_cnt_o increments.
  - If ln_sel != 0 or px_cnt != 0 before the beat, sof_err_o pulses.
- **Non-SOF, non-tlast beat**: px_cnt increments.
- **tlast beat**
  - Final length L = px_cnt + 1.
  - px_cnt goes to 0 and ln_sel increments, wrapping 7 to 0.
  - If ln_sel was 7, stripe_done_o pulses.
  - If L[2:0] != 0, width_err_o pulses.
  - If ref_vld = 0, ref_len is loaded with L and ref_vld is set.
  - Otherwise, if L != ref_len, len_err_o pulses.
  - A beat with both tuser and tlast applies both rules: the SOF rules first, then the tlast rules with L = 1.
- **px_cnt saturation**: px_cnt saturates at MAX_LINE_PX. No wrap.
- **No data dropped on errors**: errors are reporting only; every accepted beat is forwarded.

## Timing
- Latency: an accepted input beat appears on its lane in the next cycle.
- video_i.tready = !hold_vld || lines_o[hold_lane].tready (combinational).
  - This gives full throughput of 1 beat/cycle while the target lane is ready.
- Holding register:
  - hold_vld is set on acceptance.
  - hold_vld is cleared when the selected lane handshakes and no new beat is accepted in the same cycle.
  - Handshake and acceptance in the same cycle: the register is replaced. No bubble.
- Back-pressure on lane k stalls the entire input; there is no reordering across lanes.
- Status pulses and frame_cnt_o are registered: asserted in the cycle after the triggering input handshake, high for exactly 1 cycle.
- Reset values:
  - all lines_o tvalid = 0, tdata = 0, tlast = 0, tuser = 0;
  - video_i.tready = 1;
  - ln_sel = 0, px_cnt = 0, ref_vld = 0;
  - all error and done pulses 0; frame_cnt_o = 0.
- Reset mid-line: the held beat is discarded, and the next beat is routed to lane 0.

## Test plan
- **Nominal frame**: 16x16 frame, all lanes always ready → lines 0–7 appear on lanes 0–7, lines 8–15 on lanes 0–7 again; stripe_done_o pulses twice; frame_cnt_o = 1; no errors; 1 beat/cycle.
- **Back-pressure**: lane 3 tready low for 5 cycles during line 3 → video_i.tready low for those 5 cycles; no beat lost or duplicated; pixel order per lane preserved.
- **Width error**: a 12-pixel line → width_err_o pulses once at its tlast; data still forwarded intact.
- **Length mismatch**: line 0 is 16 px, line 1 is 24 px → len_err_o pulses at line 1's tlast; ref_len stays 16.
- **Early SOF**: tuser arrives after 3 lines of a frame → sof_err_o pulses, the beat goes to lane 0, frame_cnt_o increments, ref_vld is cleared.
- **Async reset**: rst_i asserted mid-line while hold_vld = 1 → all tvalid drop to 0 immediately; after release, the first beat goes to lane 0 and frame_cnt_o = 0.
